audio_mix_sched: RTL
====================

Name: audio_mix_sched

Overview:
- Sample-rate scheduler that shares one signed multiplier across the four audio sources (PSG left/right, PCM left/right).
- Applies a per-source gain to each source, sums the two sources per channel, and saturates the result to 16 bits.
- Sits between the psg/pcm blocks and dacif in the audio subsystem and runs once per next_sample pulse.
- Replaces the unscaled 17-bit add with a gain-controlled, clamped mix and one result-valid strobe per sample.

Parameters:
- GAIN_W, 6, gain width (unsigned). Unity gain = 2^(GAIN_W-1) = 32. Product shift = GAIN_W-1 = 5.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- next_sample  input  1  one-cycle pulse requesting a new mix
- psg_left  input  16  signed PSG left sample
- psg_right  input  16  signed PSG right sample
- pcm_left  input  16  signed PCM left sample
- pcm_right  input  16  signed PCM right sample
- gain_psg  input  GAIN_W  unsigned PSG gain
- gain_pcm  input  GAIN_W  unsigned PCM gain
- overrun_clr  input  1  clears the sticky overrun flag
- left_out  output  16  signed mixed left result (registered)
- right_out  output  16  signed mixed right result (registered)
- out_valid  output  1  one-cycle strobe; outputs updated this cycle
- busy  output  1  high while a mix sequence is in progress
- overrun  output  1  sticky: a request was lost

Behaviour:
- Reset values: left_out=0, right_out=0, out_valid=0, busy=0, overrun=0, pending=0, state=IDLE.
- Reset asserted mid-sequence aborts the sequence; no out_valid is produced.
- States: IDLE, M0, M1, M2, M3, SAT.
- IDLE + next_sample at edge E:
  - latch all four samples and both gains into snapshot registers;
  - clear acc_l and acc_r;
  - go to M0.
- M0 (edge E+1): acc_l = P(psg_l, gain_psg).
- M1 (edge E+2): acc_l += P(pcm_l, gain_pcm).
- M2 (edge E+3): acc_r = P(psg_r, gain_psg).
- M3 (edge E+4): acc_r += P(pcm_r, gain_pcm).
- SAT (edge E+5): clamp acc_l and acc_r into left_out and right_out; out_valid is high in the following cycle only.
- Latency: next_sample sampled at edge E produces outputs and out_valid at edge E+5.
- Only one multiplier instance is allowed; exactly one product per M-state.
- P(x,g) definition:
  - signed 16 × unsigned GAIN_W (zero-extended) gives a 22-bit signed product;
  - arithmetic shift right by GAIN_W-1, which floors toward minus infinity;
  - result is 17-bit signed.
- Accumulators: acc_l and acc_r are 18-bit signed, so no internal overflow can occur.
- Saturation:
  - a result greater than 32767 is forced to 32767;
  - a result less than -32768 is forced to -32768;
  - otherwise the result is truncated to 16 bits.
- busy is high in M0..SAT.
- next_sample while busy: set pending=1.
  - If pending is already 1, set overrun=1 and drop the request.
- Leaving SAT:
  - if pending=1 or next_sample=1, restart at M0 with a fresh snapshot taken at that edge;
  - pending is cleared if it was consumed;
  - a simultaneous next_sample while pending=1 re-sets pending.
  - Otherwise go to IDLE.
- overrun_clr clears overrun. If it coincides with a new overrun event, set wins.
- Gain or sample changes mid-sequence have no effect; only the snapshot is used.
- left_out and right_out hold their value between strobes.

Test Plan:
- Unity mix: psg_l=1000, pcm_l=2000, psg_r=-500, pcm_r=-700, gains=32, pulse at edge E -> out_valid at E+5 only; left_out=3000, right_out=-1200; busy high E+1..E+5.
- Saturation: psg_l=pcm_l=30000, psg_r=pcm_r=-30000, gains=32 -> left_out=32767, right_out=-32768.
- Gain rounding/mute: psg_l=1000, psg_r=-1000, gain_psg=63, gain_pcm=0, pcm=12345 -> left_out=1968, right_out=-1969.
- Back-to-back: pulses at E and E+2 with different samples -> second sequence starts at E+5, second out_valid at E+10 with the values present at E+5; overrun stays 0.
- Overrun: pulses at E, E+1, E+2 -> overrun=1 from E+3; exactly two out_valid strobes (E+5, E+10); overrun_clr pulse -> overrun=0 next cycle.
- Reset mid-op: pulse at E, rst at E+2 -> no out_valid; all outputs 0; next pulse after reset behaves as in the unity mix test.

Source files
------------

// File: rtl/audio_mix_sched.sv
// Per-sample audio mixer: one shared signed multiplier applies per-source gain to
// PSG/PCM left/right, sums each channel and saturates to 16 bits.
module audio_mix_sched #(
  parameter int unsigned GAIN_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              next_sample,
  input  logic [15:0]       psg_left,
  input  logic [15:0]       psg_right,
  input  logic [15:0]       pcm_left,
  input  logic [15:0]       pcm_right,
  input  logic [GAIN_W-1:0] gain_psg,
  input  logic [GAIN_W-1:0] gain_pcm,
  input  logic              overrun_clr,
  output logic [15:0]       left_out,
  output logic [15:0]       right_out,
  output logic              out_valid,
  output logic              busy,
  output logic              overrun
);

  localparam int unsigned SMP_W  = 16;
  localparam int unsigned PROD_W = SMP_W + GAIN_W + 1;
  localparam int unsigned P_W    = 17;
  localparam int unsigned ACC_W  = 18;
  localparam int unsigned SHIFT  = GAIN_W - 1;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_M0   = 3'd1;
  localparam logic [2:0] ST_M1   = 3'd2;
  localparam logic [2:0] ST_M2   = 3'd3;
  localparam logic [2:0] ST_M3   = 3'd4;
  localparam logic [2:0] ST_SAT  = 3'd5;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

  logic [2:0]              state, state_nxt;
  logic                    load_c, pend_nxt, ovr_nxt, pending;
  logic signed [SMP_W-1:0] snap_psg_l, snap_psg_r, snap_pcm_l, snap_pcm_r;
  logic [GAIN_W-1:0]       snap_gain_psg, snap_gain_pcm;
  logic signed [ACC_W-1:0] acc_l, acc_r;
  logic signed [SMP_W-1:0] mul_x;
  logic [GAIN_W-1:0]       mul_g;
  logic signed [PROD_W-1:0] x_ext, g_ext, prod_c;
  logic signed [P_W-1:0]   p_c;

  function automatic logic [SMP_W-1:0] sat16(input logic signed [ACC_W-1:0] a);
    if (a > SAT_MAX)      return 16'h7fff;
    else if (a < SAT_MIN) return 16'h8000;
    else                  return SMP_W'(a);
  endfunction

  // Operand select for the single shared multiplier
  always_comb begin
    mul_x = snap_psg_l;
    mul_g = snap_gain_psg;
    case (state)
      ST_M1: begin mul_x = snap_pcm_l; mul_g = snap_gain_pcm; end
      ST_M2: begin mul_x = snap_psg_r; mul_g = snap_gain_psg; end
      ST_M3: begin mul_x = snap_pcm_r; mul_g = snap_gain_pcm; end
      default: ;
    endcase
  end

  assign x_ext  = PROD_W'(mul_x);
  assign g_ext  = PROD_W'({1'b0, mul_g});
  assign prod_c = x_ext * g_ext;
  assign p_c    = P_W'(prod_c >>> SHIFT);

  // Next state, snapshot load and request/overrun bookkeeping
  always_comb begin
    state_nxt = state;
    load_c    = 1'b0;
    pend_nxt  = pending;
    ovr_nxt   = overrun;
    if (overrun_clr) ovr_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (next_sample) begin
          load_c    = 1'b1;
          state_nxt = ST_M0;
        end
      end
      ST_M0, ST_M1, ST_M2, ST_M3: begin
        state_nxt = state + 3'd1;
        if (next_sample) begin
          if (pending) ovr_nxt  = 1'b1;
          else         pend_nxt = 1'b1;
        end
      end
      ST_SAT: begin
        if (pending || next_sample) begin
          load_c    = 1'b1;
          state_nxt = ST_M0;
          pend_nxt  = pending && next_sample;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      pending       <= 1'b0;
      overrun       <= 1'b0;
      busy          <= 1'b0;
      out_valid     <= 1'b0;
      left_out      <= '0;
      right_out     <= '0;
      acc_l         <= '0;
      acc_r         <= '0;
      snap_psg_l    <= '0;
      snap_psg_r    <= '0;
      snap_pcm_l    <= '0;
      snap_pcm_r    <= '0;
      snap_gain_psg <= '0;
      snap_gain_pcm <= '0;
    end else begin
      state     <= state_nxt;
      pending   <= pend_nxt;
      overrun   <= ovr_nxt;
      busy      <= (state_nxt != ST_IDLE);
      out_valid <= (state == ST_SAT);
      if (load_c) begin
        snap_psg_l    <= psg_left;
        snap_psg_r    <= psg_right;
        snap_pcm_l    <= pcm_left;
        snap_pcm_r    <= pcm_right;
        snap_gain_psg <= gain_psg;
        snap_gain_pcm <= gain_pcm;
        acc_l         <= '0;
        acc_r         <= '0;
      end
      case (state)
        ST_M0:  acc_l <= ACC_W'(p_c);
        ST_M1:  acc_l <= acc_l + ACC_W'(p_c);
        ST_M2:  acc_r <= ACC_W'(p_c);
        ST_M3:  acc_r <= acc_r + ACC_W'(p_c);
        ST_SAT: begin
          left_out  <= sat16(acc_l);
          right_out <= sat16(acc_r);
        end
        default: ;
      endcase
    end
  end

endmodule
